// File: rtl/mst_fifo_arbiter_if.sv
// Bus between the two source FIFOs, the shared master-write FIFO and the arbiter.
// The arbiter uses the master modport; the FIFO side (or a bench) uses slave.
interface mst_fifo_arbiter_if;
   logic [17:0] s0_dout;
   logic        s0_empty;
   logic        s0_rd_en;
   logic [17:0] s1_dout;
   logic        s1_empty;
   logic        s1_rd_en;
   logic [17:0] mst_din;
   logic        mst_wr_en;
   logic        mst_full;

   // Handshake: a word moves from a source FIFO when rd_en is high at a clock edge
   // (FWFT head is valid while !empty); it reaches the master FIFO one cycle later on wr_en.
   modport master (
      input  s0_dout, s0_empty, s1_dout, s1_empty, mst_full,
      output s0_rd_en, s1_rd_en, mst_din, mst_wr_en
   );

   modport slave (
      output s0_dout, s0_empty, s1_dout, s1_empty, mst_full,
      input  s0_rd_en, s1_rd_en, mst_din, mst_wr_en
   );
endinterface

// File: rtl/mst_fifo_arbiter.sv
// Packet-granular arbiter sharing the PCIe master-write FIFO between receive DMA (src0)
// and the completion/register path (src1). Words: bit17 SOP, bit16 EOP, bits15:0 payload.
module mst_fifo_arbiter #(
   parameter bit PRIO_MODE = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 en,
   input  logic                 err_clr,
   mst_fifo_arbiter_if.master   bus,
   output logic [1:0]           grant,
   output logic                 busy,
   output logic [CNT_W-1:0]     s0_pkt_cnt,
   output logic [CNT_W-1:0]     s1_pkt_cnt,
   output logic                 proto_err
);

   typedef enum logic {ST_IDLE, ST_PKT} state_t;

   state_t           r_state;
   logic             r_run;
   logic             r_last_g;
   logic [1:0]       r_grant;
   logic [17:0]      r_din;
   logic             r_wr;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;
   logic             r_err;

   logic             w_cand0, w_cand1, w_bad0, w_bad1, w_win;
   logic             w_rd0, w_rd1, w_pop, w_discard, w_sop_grant, w_fwd, w_err_set;
   logic [17:0]      w_word;

   assign w_cand0 = !bus.s0_empty &  bus.s0_dout[17];
   assign w_cand1 = !bus.s1_empty &  bus.s1_dout[17];
   assign w_bad0  = !bus.s0_empty & !bus.s0_dout[17];
   assign w_bad1  = !bus.s1_empty & !bus.s1_dout[17];

   // w_win: 0 = src0, 1 = src1; a round-robin tie goes to the source not granted last
   assign w_win = PRIO_MODE ? !w_cand0
                            : ((w_cand0 & w_cand1) ? !r_last_g : w_cand1);

   always_comb begin
      w_rd0       = 1'b0;
      w_rd1       = 1'b0;
      w_discard   = 1'b0;
      w_sop_grant = 1'b0;
      if (r_run && !bus.mst_full) begin
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  if (w_bad0) begin
                     w_rd0     = 1'b1;
                     w_discard = 1'b1;
                  end else if (w_bad1) begin
                     w_rd1     = 1'b1;
                     w_discard = 1'b1;
                  end else if (w_cand0 || w_cand1) begin
                     w_sop_grant = 1'b1;
                     w_rd0       = !w_win;
                     w_rd1       =  w_win;
                  end
               end
            end
            ST_PKT: begin
               w_rd0 = r_grant[0] & !bus.s0_empty;
               w_rd1 = r_grant[1] & !bus.s1_empty;
            end
            default: ;
         endcase
      end
   end

   assign w_pop     = w_rd0 | w_rd1;
   assign w_word    = w_rd1 ? bus.s1_dout : bus.s0_dout;
   assign w_fwd     = w_pop & !w_discard;
   assign w_err_set = w_discard | ((r_state == ST_PKT) & w_pop & w_word[17] & !w_word[16]);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state  <= ST_IDLE;
         r_run    <= 1'b0;
         r_last_g <= 1'b1;
         r_grant  <= 2'b00;
         r_din    <= '0;
         r_wr     <= 1'b0;
         r_cnt0   <= '0;
         r_cnt1   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_run <= 1'b1;
         r_wr  <= w_fwd;
         if (w_fwd) r_din <= w_word;
         if (w_fwd && w_word[16]) begin
            if (w_rd1) r_cnt1 <= r_cnt1 + CNT_W'(1);
            else       r_cnt0 <= r_cnt0 + CNT_W'(1);
         end
         // A new error in the same cycle as err_clr keeps the flag set
         r_err <= w_err_set | (r_err & !err_clr);
         case (r_state)
            ST_IDLE: begin
               if (w_sop_grant) begin
                  r_grant  <= w_rd1 ? 2'b10 : 2'b01;
                  r_last_g <= w_rd1;
                  if (!w_word[16]) r_state <= ST_PKT;
               end else begin
                  r_grant <= 2'b00;
               end
            end
            ST_PKT: begin
               if (w_pop && w_word[16]) begin
                  r_state <= ST_IDLE;
                  r_grant <= 2'b00;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.s0_rd_en  = w_rd0;
   assign bus.s1_rd_en  = w_rd1;
   assign bus.mst_din   = r_din;
   assign bus.mst_wr_en = r_wr;
   assign grant         = r_grant;
   assign busy          = (r_state == ST_PKT);
   assign s0_pkt_cnt    = r_cnt0;
   assign s1_pkt_cnt    = r_cnt1;
   assign proto_err     = r_err;

endmodule
